// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Serial bit-pattern detector with a runtime-loadable pattern, selectable
//   overlapping / non-overlapping matching, an input-valid qualifier and a
//   saturating match counter. The match pulse is registered: it appears the
//   cycle after the bit that completes the pattern.
//
// Optional build macro:
//   SEQ_DET_MASK_EN  adds a per-bit compare mask (0 = don't care) that is
//                    latched together with the pattern.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   in            serial data bit
//   in_valid      in is sampled only when 1
//   pattern       pattern to load; bit LEN-1 is compared with the oldest bit
//   mask          (SEQ_DET_MASK_EN only) compare mask, loaded with pattern
//   pattern_load  latch pattern (and mask); clears history and count
//   overlap       1 = overlapping matches, 0 = history cleared after a match
//   out           one-cycle match pulse
//   match_count   saturating number of matches since reset or load
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int                LEN         = 5,
  parameter logic [LEN-1:0]    RST_PATTERN = LEN'(5'b10001),
  parameter int                COUNT_W     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic [LEN-1:0]     pattern,
`ifdef SEQ_DET_MASK_EN
  input  logic [LEN-1:0]     mask,
`endif
  input  logic               pattern_load,
  input  logic               overlap,
  output logic               out,
  output logic [COUNT_W-1:0] match_count
);

  localparam int                 FILL_W    = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(LEN);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Registered state and its next-state values.
  logic [LEN-1:0]     hist_q,  hist_d;
  logic [FILL_W-1:0]  fill_q,  fill_d;
  logic [LEN-1:0]     pat_q,   pat_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               out_q,   out_d;
`ifdef SEQ_DET_MASK_EN
  logic [LEN-1:0]     mask_q,  mask_d;
`endif

  // Candidate values for the sample currently presented.
  logic [LEN-1:0]     next_hist;
  logic [FILL_W-1:0]  next_fill;
  logic [LEN-1:0]     diff;
  logic               hit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    next_hist = {hist_q[LEN-2:0], in};
    next_fill = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
`ifdef SEQ_DET_MASK_EN
    diff      = (next_hist ^ pat_q) & mask_q;
`else
    diff      = next_hist ^ pat_q;
`endif
    // The fill gate keeps reset/cleared zeros from matching a pattern
    // that has leading zeros.
    hit       = (next_fill == FILL_MAX) && (diff == '0);

    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    count_d   = count_q;
    out_d     = 1'b0;
`ifdef SEQ_DET_MASK_EN
    mask_d    = mask_q;
`endif

    if (pattern_load) begin
      // Load wins over a simultaneous sample; that sample is dropped.
      pat_d   = pattern;
`ifdef SEQ_DET_MASK_EN
      mask_d  = mask;
`endif
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (in_valid) begin
      if (hit) begin
        out_d = 1'b1;
        if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
        // overlap is only consulted here, so changing it never disturbs
        // history that is already collected.
        if (overlap) begin
          hist_d = next_hist;
          fill_d = FILL_MAX;
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = next_hist;
        fill_d = next_fill;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PATTERN;
      count_q <= '0;
      out_q   <= 1'b0;
`ifdef SEQ_DET_MASK_EN
      mask_q  <= '1;
`endif
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      count_q <= count_d;
      out_q   <= out_d;
`ifdef SEQ_DET_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign out         = out_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//   Self-checking bench for seq_detector_param. Two instances share one
//   stimulus stream: the default build (COUNT_W=8) and a COUNT_W=2 build used
//   to reach counter saturation. A queue-based reference model tracks the
//   received bits and the match count; a compare process checks both DUTs
//   against it every cycle, and directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  localparam int LEN = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic           din;
  logic           din_valid;
  logic [LEN-1:0] pattern;
  logic [LEN-1:0] mask;
  logic           pattern_load;
  logic           overlap;
  logic           out8, out2;
  logic [7:0]     cnt8;
  logic [1:0]     cnt2;

  int checks = 0;
  int errors = 0;
  bit run    = 0;

  always #5 clock = ~clock;

  seq_detector_param #(.LEN(LEN), .COUNT_W(8)) dut8 (
    .clock(clock), .reset(reset), .in(din), .in_valid(din_valid),
    .pattern(pattern),
`ifdef SEQ_DET_MASK_EN
    .mask(mask),
`endif
    .pattern_load(pattern_load), .overlap(overlap),
    .out(out8), .match_count(cnt8)
  );

  seq_detector_param #(.LEN(LEN), .COUNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .in(din), .in_valid(din_valid),
    .pattern(pattern),
`ifdef SEQ_DET_MASK_EN
    .mask(mask),
`endif
    .pattern_load(pattern_load), .overlap(overlap),
    .out(out2), .match_count(cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: bits received since the last clear, oldest first.
  // ---------------------------------------------------------------------------
  bit             mq[$];
  logic [LEN-1:0] mpat  = 5'b10001;
  logic [LEN-1:0] mmask = '1;
  int             mcnt  = 0;
  bit             mout  = 0;

  function automatic bit model_match();
    if (mq.size() != LEN) return 0;
    for (int i = 0; i < LEN; i++)
      if (mmask[LEN-1-i] && (mq[i] != mpat[LEN-1-i])) return 0;
    return 1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      mpat  = 5'b10001;
      mmask = '1;
      mcnt  = 0;
      mout  = 0;
    end else begin
      mout = 0;
      if (pattern_load) begin
        mpat = pattern;
`ifdef SEQ_DET_MASK_EN
        mmask = mask;
`endif
        mq.delete();
        mcnt = 0;
      end else if (din_valid) begin
        mq.push_back(din);
        if (mq.size() > LEN) void'(mq.pop_front());
        if (model_match()) begin
          mout = 1;
          mcnt++;
          if (!overlap) mq.delete();
        end
      end
    end
  end

  // Every-cycle comparison, half a period after the active edge.
  always @(negedge clock) begin
    if (run) begin
      check("cyc_out8", out8, mout);
      check("cyc_cnt8", cnt8, (mcnt > 255) ? 255 : mcnt);
      check("cyc_out2", out2, mout);
      check("cyc_cnt2", cnt2, (mcnt > 3) ? 3 : mcnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the active edge.
  // ---------------------------------------------------------------------------
  int pulses;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input bit b);
    din = b; din_valid = 1'b1; pattern_load = 1'b0;
    tick();
    pulses += int'(out8);
  endtask

  task automatic idle(input bit b);
    din = b; din_valid = 1'b0; pattern_load = 1'b0;
    tick();
    pulses += int'(out8);
  endtask

  task automatic load(input logic [LEN-1:0] p, input bit valid, input bit b);
    pattern = p; mask = '1; pattern_load = 1'b1; din_valid = valid; din = b;
    tick();
    pattern_load = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) send(v[i]);
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; pattern = '0; mask = '1;
    pattern_load = 1'b0; overlap = 1'b1;
    tick();
    run = 1;
    tick();
    check("rst_out", out8, 0);
    check("rst_cnt", cnt8, 0);
    reset = 1'b0;

    // Basic match with the reset pattern 10001.
    pulses = 0;
    send_bits(16'b10001, 5);
    check("basic_out", out8, 1);
    check("basic_cnt", cnt8, 1);
    idle(1'b0);
    check("basic_out_drop", out8, 0);
    check("basic_pulses", pulses, 1);

    // Overlapping: two pulses from 100010001.
    pulse_reset();
    overlap = 1'b1; pulses = 0;
    send_bits(16'b100010001, 9);
    check("ovl_pulses", pulses, 2);
    check("ovl_cnt", cnt8, 2);

    // Non-overlapping: the shared 1 is consumed, one pulse only.
    pulse_reset();
    overlap = 1'b0; pulses = 0;
    send_bits(16'b100010001, 9);
    check("novl_pulses", pulses, 1);
    check("novl_cnt", cnt8, 1);

    // Load with a simultaneous valid sample: sample dropped, count cleared.
    overlap = 1'b1;
    load(5'b11011, 1'b1, 1'b1);
    check("load_cnt_clr", cnt8, 0);
    pulses = 0;
    send_bits(16'b1101, 4);
    check("load_no_early", pulses, 0);
    send(1'b1);
    check("load_out", out8, 1);
    check("load_cnt", cnt8, 1);

    // Idle cycles with in toggling are ignored.
    load(5'b10001, 1'b0, 1'b0);
    pulses = 0;
    send_bits(16'b100, 3);
    idle(1'b1); idle(1'b0); idle(1'b1);
    send(1'b0);
    check("gap_no_early", pulses, 0);
    send(1'b1);
    check("gap_out", out8, 1);
    check("gap_cnt", cnt8, 1);

    // Saturation: 12 ones against 11111 with overlap -> 8 pulses.
    load(5'b11111, 1'b0, 1'b0);
    overlap = 1'b1; pulses = 0;
    for (int i = 0; i < 12; i++) send(1'b1);
    check("sat_pulses", pulses, 8);
    check("sat_cnt2", cnt2, 3);
    check("sat_cnt8", cnt8, 8);

    // Asynchronous reset mid-stream.
    load(5'b10001, 1'b0, 1'b0);
    send_bits(16'b10001000, 8);
    check("pre_rst_cnt", cnt8, 1);
    #2 reset = 1'b1;
    #1;
    check("async_out", out8, 0);
    check("async_cnt", cnt8, 0);
    check("async_cnt2", cnt2, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    pulses = 0;
    send(1'b1);
    check("post_rst_single", out8, 0);
    send_bits(16'b0001, 4);
    check("post_rst_out", out8, 1);
    check("post_rst_pulses", pulses, 1);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      pattern_load = ($urandom_range(0, 39) == 0);
      pattern      = ($urandom_range(0, 1) == 0) ? LEN'($urandom) : 5'b10101;
      mask         = LEN'($urandom) | 5'b10001;
      din          = 1'($urandom);
      din_valid    = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 19) == 0) overlap = ~overlap;
      tick();
    end
    reset = 1'b0; pattern_load = 1'b0; din_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
